// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state indices into the
// one-hot state vector, instruction class and branch condition codes,
// status bit positions and a helper that builds a one-hot state word.
package control_sequencer_pkg;

  localparam int NUM_STATES = 13;

  // Bit position of each state inside the one-hot state vector.
  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_OPERAND    = 4'd2,
    S_ALU_EXEC   = 4'd3,
    S_ALU_IMM    = 4'd4,
    S_MEM_ACCESS = 4'd5,
    S_BR_EVAL    = 4'd6,
    S_BR_TAKE    = 4'd7,
    S_ADDR_CALC  = 4'd8,
    S_SHIFT      = 4'd9,
    S_CALL_LINK  = 4'd10,
    S_PC_INC     = 4'd11,
    S_TRAP       = 4'd12
  } state_idx_e;

  // Instruction class carried in ir[15:14].
  typedef enum logic [1:0] {
    CLS_ALU    = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_SYS    = 2'b11
  } instr_class_e;

  // Branch condition carried in ir[10:8].
  typedef enum logic [2:0] {
    COND_JMP = 3'b000,
    COND_BA  = 3'b001,
    COND_BNE = 3'b010,
    COND_BE  = 3'b011,
    COND_BG  = 3'b100,
    COND_BLE = 3'b101,
    COND_BGE = 3'b110,
    COND_BL  = 3'b111
  } branch_cond_e;

  // Positions inside the status bus.
  localparam int ST_Z   = 0;
  localparam int ST_N   = 1;
  localparam int ST_V   = 2;
  localparam int ST_C   = 3;
  localparam int ST_IRQ = 4;

  function automatic logic [NUM_STATES-1:0] state_bit(input state_idx_e s);
    state_bit = NUM_STATES'(1) << s;
  endfunction

endpackage

// File: rtl/control_sequencer_cond.sv
// branch_cond_eval: decides whether a conditional branch is taken from the
// 3-bit condition code and the Z/N/V status flags.
module branch_cond_eval
  import control_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [4:0] status,
  output logic       taken
);

  logic z, n, v, lt;
  logic unused_status;

  assign z  = status[ST_Z];
  assign n  = status[ST_N];
  assign v  = status[ST_V];
  assign lt = n ^ v;
  // Carry and interrupt request play no part in branch decisions.
  assign unused_status = status[ST_C] ^ status[ST_IRQ];

  // Signed-compare style condition table.
  always_comb begin
    taken = 1'b0;
    case (branch_cond_e'(cond))
      COND_JMP: taken = 1'b1;
      COND_BA:  taken = 1'b1;
      COND_BNE: taken = ~z;
      COND_BE:  taken = z;
      COND_BG:  taken = ~z & ~lt;
      COND_BLE: taken = z | lt;
      COND_BGE: taken = ~lt;
      COND_BL:  taken = lt;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: one-hot instruction control FSM (fetch, decode,
// execute, branch, memory access, interrupt trap).
// Optional build macro SEQ_MEM_TIMEOUT_EN adds a memory wait timeout that
// forces TRAP and pulses bus_err; without it waits are unbounded.
//
// Memory handshake: mem_req is high while the FSM sits in FETCH or
// MEM_ACCESS; the access completes on the rising edge where mem_ready=1,
// and the FSM holds its state for every cycle mem_ready=0.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic [4:0]  status,
  input  logic        mem_ready,
  output logic [12:0] state,
  output logic        mem_req,
  output logic        mem_rw,
  output logic        ir_load,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  logic [NUM_STATES-1:0] state_q, state_d;
  logic onehot_ok;
  logic taken;
  logic timeout;
  logic unused_ir;

  assign onehot_ok = $onehot(state_q);
  // Opcode bits consumed by the datapath, not by sequencing.
  assign unused_ir = ^{ir[12], ir[7:5], ir[3:0]};

  branch_cond_eval u_cond (
    .cond   (ir[10:8]),
    .status (status),
    .taken  (taken)
  );

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       waiting;
  logic       bus_err_q;

  assign waiting = onehot_ok & (state_q[S_FETCH] | state_q[S_MEM_ACCESS]) & ~mem_ready;
  // The limit is hit on the wait cycle that would make the count reach
  // TIMEOUT_CYCLES; a cycle with mem_ready=1 is not a wait, so it wins.
  assign timeout = waiting && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Consecutive wait counter and the one-cycle bus error flag for TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= waiting ? wait_cnt_q + 8'd1 : 8'd0;
      bus_err_q  <= timeout;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // State register; reset forces FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_bit(S_FETCH);
    else        state_q <= state_d;
  end

  // Next-state decode; any corrupted (non-one-hot) value falls back to FETCH.
  always_comb begin
    state_d = state_bit(S_FETCH);
    if (onehot_ok) begin
      case (1'b1)
        state_q[S_FETCH]:
          state_d = mem_ready ? state_bit(S_DECODE) : state_bit(S_FETCH);
        state_q[S_DECODE]:
          case (instr_class_e'(ir[15:14]))
            CLS_ALU:    state_d = state_bit(S_OPERAND);
            CLS_MEM:    state_d = state_bit(S_ADDR_CALC);
            CLS_BRANCH: state_d = state_bit(S_BR_EVAL);
            default:    state_d = ir[13] ? state_bit(S_CALL_LINK) : state_bit(S_SHIFT);
          endcase
        state_q[S_OPERAND]:
          state_d = ir[4] ? state_bit(S_ALU_IMM) : state_bit(S_ALU_EXEC);
        state_q[S_ALU_EXEC]:   state_d = state_bit(S_PC_INC);
        state_q[S_ALU_IMM]:    state_d = state_bit(S_PC_INC);
        state_q[S_SHIFT]:      state_d = state_bit(S_PC_INC);
        state_q[S_ADDR_CALC]:  state_d = state_bit(S_MEM_ACCESS);
        state_q[S_MEM_ACCESS]:
          state_d = mem_ready ? state_bit(S_PC_INC) : state_bit(S_MEM_ACCESS);
        state_q[S_BR_EVAL]:
          state_d = taken ? state_bit(S_BR_TAKE) : state_bit(S_PC_INC);
        state_q[S_CALL_LINK]:  state_d = state_bit(S_BR_TAKE);
        state_q[S_BR_TAKE]:    state_d = state_bit(S_FETCH);
        state_q[S_PC_INC]:
          state_d = status[ST_IRQ] ? state_bit(S_TRAP) : state_bit(S_FETCH);
        state_q[S_TRAP]:       state_d = state_bit(S_FETCH);
        default:               state_d = state_bit(S_FETCH);
      endcase
      if (timeout) state_d = state_bit(S_TRAP);
    end
  end

  assign state   = state_q;
  assign mem_req = state_q[S_FETCH] | state_q[S_MEM_ACCESS];
  assign mem_rw  = state_q[S_MEM_ACCESS] & ir[11];
  assign ir_load = state_q[S_FETCH] & mem_ready;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model through an expected queue.
module tb_control_sequencer;

  localparam int TIMEOUT = 15;

  // Model state numbering (bit index in the one-hot state output).
  localparam int FETCH = 0, DECODE = 1, OPERAND = 2, ALU_EXEC = 3, ALU_IMM = 4,
                 MEM_ACCESS = 5, BR_EVAL = 6, BR_TAKE = 7, ADDR_CALC = 8,
                 SHIFT = 9, CALL_LINK = 10, PC_INC = 11, TRAP = 12;

  logic        clk;
  logic        rst_n;
  logic [15:0] ir;
  logic [4:0]  status;
  logic        mem_ready;
  logic [12:0] state;
  logic        mem_req, mem_rw, ir_load, bus_err;

  logic [16:0] exp_q[$];
  int n_vectors;
  int n_fail;

  int m_state;
  int m_waits;
  bit m_berr;

  control_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir        (ir),
    .status    (status),
    .mem_ready (mem_ready),
    .state     (state),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .ir_load   (ir_load),
    .bus_err   (bus_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model helpers ----------------
  function automatic bit cond_true(input logic [2:0] c, input logic [4:0] s);
    bit z, lt;
    z  = s[0];
    lt = (s[1] != s[2]);
    case (c)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return !z;
      3'd3:       return z;
      3'd4:       return !z && !lt;
      3'd5:       return z || lt;
      3'd6:       return !lt;
      default:    return lt;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle of inputs, records the
  // outputs expected during that cycle, advances the model, waits an edge.
  task automatic apply(input logic [15:0] a_ir, input logic [4:0] a_st,
                       input logic a_mr, input logic a_rst_n);
    logic [16:0] e;
    int nxt;
    bit is_wait;
    ir = a_ir; status = a_st; mem_ready = a_mr; rst_n = a_rst_n;
    if (!a_rst_n) begin
      m_state = FETCH; m_waits = 0; m_berr = 1'b0;
    end
    e = {13'(1 << m_state),
         (m_state == FETCH) || (m_state == MEM_ACCESS),
         (m_state == MEM_ACCESS) && a_ir[11],
         (m_state == FETCH) && a_mr,
         m_berr};
    exp_q.push_back(e);
    n_vectors++;
    if (a_rst_n) begin
      case (m_state)
        FETCH:      nxt = a_mr ? DECODE : FETCH;
        DECODE:     nxt = (a_ir[15:14] == 2'd0) ? OPERAND :
                          (a_ir[15:14] == 2'd1) ? ADDR_CALC :
                          (a_ir[15:14] == 2'd2) ? BR_EVAL :
                          (a_ir[13] ? CALL_LINK : SHIFT);
        OPERAND:    nxt = a_ir[4] ? ALU_IMM : ALU_EXEC;
        ALU_EXEC, ALU_IMM, SHIFT: nxt = PC_INC;
        ADDR_CALC:  nxt = MEM_ACCESS;
        MEM_ACCESS: nxt = a_mr ? PC_INC : MEM_ACCESS;
        BR_EVAL:    nxt = cond_true(a_ir[10:8], a_st) ? BR_TAKE : PC_INC;
        CALL_LINK:  nxt = BR_TAKE;
        BR_TAKE:    nxt = FETCH;
        PC_INC:     nxt = a_st[4] ? TRAP : FETCH;
        default:    nxt = FETCH;
      endcase
      m_berr = 1'b0;
      is_wait = ((m_state == FETCH) || (m_state == MEM_ACCESS)) && !a_mr;
`ifdef SEQ_MEM_TIMEOUT_EN
      if (is_wait && (m_waits + 1 == TIMEOUT)) begin
        nxt = TRAP;
        m_berr = 1'b1;
      end
`endif
      m_waits = is_wait ? m_waits + 1 : 0;
      m_state = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] a_ir, input logic [4:0] a_st,
                     input logic a_mr, input int n);
    for (int i = 0; i < n; i++) apply(a_ir, a_st, a_mr, 1'b1);
  endtask

  task automatic do_reset();
    apply(16'h0000, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [16:0] exp_v, act;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {state, mem_req, mem_rw, ir_load, bus_err};
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_%0d outputs: got state=%h req=%b rw=%b load=%b berr=%b, expected state=%h req=%b rw=%b load=%b berr=%b",
                   cyc, act[16:4], act[3], act[2], act[1], act[0],
                   exp_v[16:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
        cyc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    n_vectors = 0;
    n_fail = 0;
    m_state = FETCH; m_waits = 0; m_berr = 1'b0;
    rst_n = 1'b0; ir = '0; status = '0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held across edges.
    do_reset();
    do_reset();

    // ALU immediate path.
    run(16'h0010, 5'b00000, 1'b1, 6);

    // Branch taken (be with Z=1) and not taken (Z=0).
    do_reset();
    run(16'h8300, 5'b00001, 1'b1, 5);
    do_reset();
    run(16'h8300, 5'b00000, 1'b1, 5);

    // Memory write with three wait cycles.
    do_reset();
    run(16'h4800, 5'd0, 1'b1, 3);
    run(16'h4800, 5'd0, 1'b0, 3);
    run(16'h4800, 5'd0, 1'b1, 3);

    // Interrupt at PC_INC via register ALU op.
    do_reset();
    run(16'h0000, 5'b10000, 1'b1, 7);

    // Call/link and shift paths.
    do_reset();
    run(16'hE000, 5'd0, 1'b1, 5);
    run(16'hC000, 5'd0, 1'b1, 5);

    // Long fetch wait past the limit, then wait ending on the limit cycle.
    do_reset();
    run(16'h0000, 5'd0, 1'b0, TIMEOUT + 3);
    do_reset();
    run(16'h0000, 5'd0, 1'b0, TIMEOUT - 1);
    run(16'h0000, 5'd0, 1'b1, 4);

    // Long memory wait.
    do_reset();
    run(16'h4000, 5'd0, 1'b1, 3);
    run(16'h4000, 5'd0, 1'b0, TIMEOUT + 2);
    run(16'h4000, 5'd0, 1'b1, 3);

    // Reset asserted in the middle of a memory access, then restart.
    do_reset();
    run(16'h4800, 5'd0, 1'b1, 3);
    run(16'h4800, 5'd0, 1'b0, 2);
    do_reset();
    do_reset();
    run(16'h0010, 5'd0, 1'b1, 6);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      apply(16'($urandom),
            5'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 5'b10000 : 5'b00000),
            ($urandom_range(0, 3) != 0) || ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 149) != 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule
